// File: rtl/memory_access.sv
// Memory-access pipeline stage: holds the M register, runs the data-memory
// request/response handshake, and flags misaligned accesses and read timeouts.
//
// state | meaning
// IDLE  | no transaction pending; M register captures each cycle, wb_valid_m high
// REQ   | request presented on dmem_req_*, waiting for dmem_req_ready
// WAIT  | read accepted, waiting for dmem_resp_valid or timeout
module memory_access #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_out_e,
   input  logic [31:0] write_data_e,
   input  logic [4:0]  write_reg_e,
   input  logic        reg_write_e,
   input  logic        mem_to_reg_e,
   input  logic        mem_write_e,
   input  logic        mem_access_e,
   output logic        stall_m,
   output logic        dmem_req_valid,
   output logic        dmem_req_we,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_wdata,
   input  logic        dmem_req_ready,
   input  logic        dmem_resp_valid,
   input  logic [31:0] dmem_resp_rdata,
   output logic [31:0] alu_out_m,
   output logic [31:0] read_data_m,
   output logic [4:0]  write_reg_m,
   output logic        reg_write_m,
   output logic        mem_to_reg_m,
   output logic        wb_valid_m,
   output logic        misaligned_m,
   output logic        bus_err_m
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_d;
   logic [7:0]  cnt, cnt_d;
   logic [31:0] read_data_d;
   logic        bus_err_d;

   logic [31:0] alu_out_q;
   logic [31:0] write_data_q;
   logic [4:0]  write_reg_q;
   logic        reg_write_q;
   logic        mem_to_reg_q;
   logic        mem_write_q;
   logic        mem_access_q;

   assign stall_m = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_out_q    <= '0;
         write_data_q <= '0;
         write_reg_q  <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_access_q <= 1'b0;
      end else if (!stall_m) begin
         alu_out_q    <= alu_out_e;
         write_data_q <= write_data_e;
         write_reg_q  <= write_reg_e;
         reg_write_q  <= reg_write_e;
         mem_to_reg_q <= mem_to_reg_e;
         mem_write_q  <= mem_write_e;
         mem_access_q <= mem_access_e;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         read_data_m <= '0;
         bus_err_m   <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         read_data_m <= read_data_d;
         bus_err_m   <= bus_err_d;
      end
   end

   // bus_err_d defaults low so the error flag lives for exactly one IDLE cycle
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      read_data_d = read_data_m;
      bus_err_d   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_access_e && (alu_out_e[1:0] == 2'b00)) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (dmem_req_ready) begin
               if (mem_write_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT: begin
            if (dmem_resp_valid) begin
               read_data_d = dmem_resp_rdata;
               state_d     = IDLE;
            end else if (cnt == CNT_LAST) begin
               read_data_d = '0;
               bus_err_d   = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request fields are zero outside REQ so an idle bus never shows stale data
   assign dmem_req_valid = (state == REQ);
   assign dmem_req_we    = (state == REQ) && mem_write_q;
   assign dmem_req_addr  = (state == REQ) ? alu_out_q : '0;
   assign dmem_req_wdata = (state == REQ) ? write_data_q : '0;

   assign wb_valid_m   = (state == IDLE);
   assign misaligned_m = wb_valid_m && mem_access_q && (alu_out_q[1:0] != 2'b00);
   assign reg_write_m  = reg_write_q && wb_valid_m && !misaligned_m && !bus_err_m;

   assign alu_out_m    = alu_out_q;
   assign write_reg_m  = write_reg_q;
   assign mem_to_reg_m = mem_to_reg_q;

endmodule
